// File: rtl/dmem_port_arbiter_pkg.sv
// Shared defaults and state encoding for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [DW_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory owner: zero-fill sweep, then core/debug arbitration
// with a starvation limit on the debug requester.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = 4,
  parameter bit          CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          c_rd,
  input  logic          c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned      SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
  localparam state_e           RST_STATE  = CLR_ON_RST ? ST_CLEAR : ST_RUN;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            clr_done_q, clr_done_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;

  logic c_req, d_elig, in_run, dbg_win, core_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RST_STATE;
      clr_addr_q   <= '0;
      clr_done_q   <= 1'b0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_done_q   <= clr_done_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // The ack cycle masks d_req so a request still held high is not served twice.
  always_comb begin
    c_req    = c_rd | c_wr;
    d_elig   = d_req & ~d_ack_q;
    in_run   = (state_q == ST_RUN);
    dbg_win  = in_run & d_elig & (~c_req | (starve_cnt_q == STARVE_LIM));
    core_win = in_run & c_req & ~dbg_win;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!in_run) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr_q;
    end else if (dbg_win) begin
      mem_we    = d_we;
      mem_re    = ~d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (core_win) begin
      mem_we    = c_wr;
      mem_re    = c_rd & ~c_wr;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
    if (rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_done_d   = 1'b0;
    d_ack_d      = dbg_win;
    d_rdata_d    = (dbg_win && !d_we) ? mem_rdata : d_rdata_q;
    starve_cnt_d = starve_cnt_q;

    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d    = ST_RUN;
          clr_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase

    if (dbg_win || !d_elig) begin
      starve_cnt_d = '0;
    end else if (core_win && starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;
  assign c_rdata  = mem_rdata;
  assign c_stall  = c_req & (dbg_win | ~in_run);
  assign d_ack    = d_ack_q;
  assign d_rdata  = d_rdata_q;

endmodule
